// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: the FSM state encoding,
// the default bit period and the idle line level.
package uart_pkg;

    // Serializer states. PARITY is reached only when UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Default number of sample_tick pulses per bit (16x oversampling).
    localparam int UART_TICKS_PER_BIT = 16;

    // Level of the tx line when no frame is in flight (mark).
    localparam logic UART_LINE_IDLE = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. The search starts at last_grant+1 and wraps
// modulo NUM_REQ, so the most recently served requester has lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int SUM_W = IDX_W + 1;

    // w_cand[k] is the requester index examined at search position k.
    logic [IDX_W-1:0] w_cand [NUM_REQ];
    logic             w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SUM_W-1:0] w_sum;
            assign w_sum = {1'b0, last_grant} + SUM_W'(gi + 1);
            // One conditional subtract is enough: the sum never reaches 2*NUM_REQ.
            assign w_cand[gi] = (w_sum >= SUM_W'(NUM_REQ)) ?
                                IDX_W'(w_sum - SUM_W'(NUM_REQ)) : w_sum[IDX_W-1:0];
        end
    endgenerate

    // Take the first asserted request in search order.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[w_cand[k]]) begin
                w_found           = 1'b1;
                grant_idx         = w_cand[k];
                grant[w_cand[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART tx line among NUM_REQ byte sources.
// Frames are start / DATA_W data bits (LSB first) / stop; bit timing comes from
// sample_tick. Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    uart_state_t         r_state, w_state_next;
    logic [TICK_W-1:0]   r_tick_cnt, w_tick_next;
    logic [BIT_W-1:0]    r_bit_cnt, w_bit_next;
    logic [DATA_W-1:0]   r_shift, w_shift_next;
    logic                r_tx, w_tx_next;
    logic                r_busy, w_busy_next;
    logic [IDX_W-1:0]    r_grant_id, w_grant_id_next;
    logic [IDX_W-1:0]    r_last_grant, w_last_grant_next;
`ifdef UART_TX_PARITY_EN
    logic                r_parity, w_parity_next;
`endif

    logic [DATA_W-1:0]   w_req_bytes [NUM_REQ];
    logic [DATA_W-1:0]   w_grant_byte;
    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_bit_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_arb_grant),
        .grant_idx  (w_arb_idx)
    );

    assign w_grant_byte = w_req_bytes[w_arb_idx];
    assign w_bit_done   = sample_tick && (r_tick_cnt == TICK_LAST);

    // Handshake is offered only while idle and never while reset is held,
    // so no byte can be accepted that the reset would then discard.
    assign req_ready = (r_state == ST_IDLE && !reset) ? w_arb_grant : '0;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;

    // Next-state, counter and line-level logic for the serializer.
    always_comb begin
        w_state_next      = r_state;
        w_tick_next       = r_tick_cnt;
        w_bit_next        = r_bit_cnt;
        w_shift_next      = r_shift;
        w_grant_id_next   = r_grant_id;
        w_last_grant_next = r_last_grant;
        w_tx_next         = UART_LINE_IDLE;
`ifdef UART_TX_PARITY_EN
        w_parity_next     = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                // A tick arriving in the grant cycle is deliberately dropped.
                w_tick_next = '0;
                w_bit_next  = '0;
                if (|req_valid) begin
                    w_state_next      = ST_START;
                    w_shift_next      = w_grant_byte;
                    w_grant_id_next   = w_arb_idx;
                    w_last_grant_next = w_arb_idx;
`ifdef UART_TX_PARITY_EN
                    w_parity_next     = ^w_grant_byte;
`endif
                end
            end
            default: begin
                // All in-frame states share the same bit timer.
                if (sample_tick) begin
                    w_tick_next = w_bit_done ? '0 : r_tick_cnt + 1'b1;
                end
                if (w_bit_done) begin
                    case (r_state)
                        ST_START: w_state_next = ST_DATA;
                        ST_DATA: begin
                            if (r_bit_cnt == BIT_LAST) begin
                                w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
                                w_state_next = ST_PARITY;
`else
                                w_state_next = ST_STOP;
`endif
                            end else begin
                                w_bit_next   = r_bit_cnt + 1'b1;
                                w_shift_next = r_shift >> 1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        ST_PARITY: w_state_next = ST_STOP;
`endif
                        default: w_state_next = ST_IDLE;
                    endcase
                end
            end
        endcase

        // tx is registered: drive the level belonging to the state being entered.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_parity_next;
`endif
            default:   w_tx_next = UART_LINE_IDLE;
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters, held byte, grant bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_tx         <= UART_LINE_IDLE;
            r_busy       <= 1'b0;
            r_grant_id   <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_tick_cnt   <= w_tick_next;
            r_bit_cnt    <= w_bit_next;
            r_shift      <= w_shift_next;
            r_tx         <= w_tx_next;
            r_busy       <= w_busy_next;
            r_grant_id   <= w_grant_id_next;
            r_last_grant <= w_last_grant_next;
`ifdef UART_TX_PARITY_EN
            r_parity     <= w_parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler. Requesters are modelled as byte
// queues; the expected grant order follows the round-robin rule and the
// expected tx level is derived from the count of sample_tick pulses since grant.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = W + 3;
`else
    localparam int FRAME_BITS = W + 2;
`endif
    localparam int FRAME_TICKS = FRAME_BITS * TPB;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           sample_tick = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx;
    logic           busy;
    logic [1:0]     grant_id;

    uart_tx_scheduler #(
        .NUM_REQ       (N),
        .DATA_W        (W),
        .TICKS_PER_BIT (TPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx          (tx),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int tick_period = 1;
    int tick_phase = 0;
    int model_last = N - 1;
    int last_busy_cyc = 0;

    logic [7:0] mem [N][64];
    int head [N];
    int tail [N];

    // sample_tick generator: one pulse every tick_period clocks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_phase++;
            sample_tick = ((tick_phase % tick_period) == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, observed no completion, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        mem[i][tail[i]] = b;
        tail[i]++;
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Round-robin reference: first pending requester after the last one served.
    function automatic int pick(input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (head[c] != tail[c]) return c;
        end
        return 0;
    endfunction

    // Expected tx level after n counted ticks of a frame carrying byte b.
    function automatic logic exp_line(input logic [7:0] b, input int n);
        int bi;
        bi = n / TPB;
        if (bi == 0) return 1'b0;
        if (bi <= W) return b[bi-1];
`ifdef UART_TX_PARITY_EN
        if (bi == W + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (head[i] != tail[i]);
            req_data[i*W +: W] = (head[i] != tail[i]) ? mem[i][head[i]] : 8'($urandom);
        end
    endtask

    task automatic apply();
        @(posedge clk);
        #1;
        drive_reqs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_reqs();
        @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_last = N - 1;
        @(negedge clk);
    endtask

    // Waits for the expected grant, then follows the frame tick by tick.
    // abort_at > 0 returns early once that many ticks have been counted.
    task automatic run_frame(input int abort_at);
        int id;
        int g;
        int n;
        int bad;
        int busy_cyc;
        logic [7:0] b;
        id = pick(model_last);
        b  = mem[id][head[id]];
        g  = 0;
        while (req_ready === '0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("grant_wait_ok", 32'(g < 50), 32'd1);
        check("req_ready_onehot", 32'(req_ready), 32'(1 << id));
        @(posedge clk);
        #1;
        head[id]++;
        model_last = id;
        drive_reqs();
        @(negedge clk);
        check("grant_id", 32'(grant_id), 32'(id));
        check("g1_busy", 32'(busy), 32'd1);
        check("g1_tx_start", 32'(tx), 32'd0);
        n = 0;
        bad = 0;
        busy_cyc = 0;
        while (n < FRAME_TICKS && !(abort_at > 0 && n >= abort_at)) begin
            if (tx !== exp_line(b, n) || busy !== 1'b1) bad++;
            busy_cyc++;
            if (sample_tick) n++;
            @(negedge clk);
        end
        check("frame_line_miscycles", 32'(bad), 32'd0);
        last_busy_cyc = busy_cyc;
        if (abort_at > 0) return;
        check("end_busy", 32'(busy), 32'd0);
        check("end_tx", 32'(tx), 32'd1);
        $display("frame: req %0d byte %02h ticks %0d clocks %0d", id, b, n, busy_cyc);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end

        // Reset state.
        do_reset();

        // Single request, byte 0x5A, tick tied high.
        push(1, 8'h5A);
        apply();
        run_frame(0);
        check("single_busy_cycles", 32'(last_busy_cyc), 32'(FRAME_TICKS));
        check("single_ready_once", 32'(req_ready), 32'd0);
        check("single_grant_id_hold", 32'(grant_id), 32'd1);

        // All four requesters valid from reset with distinct bytes.
        for (int i = 0; i < N; i++) push(i, {4'(i), 4'($urandom)});
        do_reset();
        for (int i = 0; i < N; i++) run_frame(0);
        check("four_drained_ready", 32'(req_ready), 32'd0);

        // Fairness: requesters 0 and 2 held valid.
        for (int k = 0; k < 3; k++) begin
            push(0, 8'($urandom));
            push(2, 8'($urandom));
        end
        apply();
        while (any_pending()) run_frame(0);

        // Tick every 4th clock; byte 0x07 also exercises parity when enabled.
        tick_period = 4;
        push(3, 8'h07);
        apply();
        run_frame(0);
        check("slow_frame_clocks_in_range",
              32'(last_busy_cyc >= FRAME_TICKS*4 - 3 && last_busy_cyc <= FRAME_TICKS*4), 32'd1);

        // Randomized traffic and tick spacing.
        for (int r = 0; r < 5; r++) begin
            tick_period = $urandom_range(1, 3);
            for (int i = 0; i < N; i++) begin
                int cnt;
                cnt = $urandom_range(0, 2);
                for (int k = 0; k < cnt; k++) push(i, 8'($urandom));
            end
            apply();
            while (any_pending()) run_frame(0);
        end

        // Reset during DATA bit 3, with other requesters waiting.
        tick_period = 1;
        push(2, 8'hC3);
        apply();
        run_frame(TPB*4 + 5);
        push(3, 8'($urandom));
        push(1, 8'($urandom));
        push(0, 8'($urandom));
        do_reset();
        check("post_reset_req0_first", 32'(req_ready), 32'd1);
        while (any_pending()) run_frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
